// File: rtl/rosco_bus_pkg.sv
// Shared bus definitions for the rosco bus glue logic.
// FSM states, external-ack sources and default wait/timeout constants.
package rosco_bus_pkg;

    localparam int DEF_ROM_WAIT = 2;
    localparam int DEF_RAM_WAIT = 0;
    localparam int DEF_TIMEOUT  = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_EXTWAIT,
        ST_ACK,
        ST_BERR
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_IO,
        SRC_EXP
    } src_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous active-low bus strobes.
// Resets to 1 so a held-low input is never seen during reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_ack_gen.sv
// DTACK / bus-error generator for the 68k bus: fixed waits for ROM/RAM,
// synchronized external acknowledge with timeout for IO and expansion.
module bus_ack_gen
    import rosco_bus_pkg::*;
#(
    parameter int ROM_WAIT = DEF_ROM_WAIT,
    parameter int RAM_WAIT = DEF_RAM_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic i_CLK,
    input  logic i_RESET_n,
    input  logic i_AS_n,
    input  logic i_ROMSEL_n,
    input  logic i_RAMSEL_n,
    input  logic i_IOSEL_n,
    input  logic i_EXPSEL_n,
    input  logic i_IODTACK_n,
    input  logic i_EXPDTACK_n,
    output logic o_DTACK_n,
    output logic o_BERR_n,
    output logic o_BUSY
);

    localparam int CW = cnt_width(ROM_WAIT, RAM_WAIT, TIMEOUT);

    logic         as_s;
    logic         iodt_s;
    logic         expdt_s;
    logic         as_prev;
    logic         ack_hit;
    state_t       state;
    state_t       state_nx;
    src_t         src;
    src_t         src_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    sync2 u_sync_as (
        .clk   (i_CLK),
        .rst_n (i_RESET_n),
        .d     (i_AS_n),
        .q     (as_s)
    );

    sync2 u_sync_iodt (
        .clk   (i_CLK),
        .rst_n (i_RESET_n),
        .d     (i_IODTACK_n),
        .q     (iodt_s)
    );

    sync2 u_sync_expdt (
        .clk   (i_CLK),
        .rst_n (i_RESET_n),
        .d     (i_EXPDTACK_n),
        .q     (expdt_s)
    );

    assign ack_hit = ((src == SRC_IO)  && !iodt_s) ||
                     ((src == SRC_EXP) && !expdt_s);

    always_comb begin
        state_nx = state;
        src_nx   = src;
        cnt_nx   = cnt;
        unique case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                // Decode only on the falling edge of the synchronized strobe
                if (!as_s && as_prev) begin
                    if (!i_ROMSEL_n) begin
                        state_nx = ST_COUNT;
                        cnt_nx   = CW'(ROM_WAIT);
                    end else if (!i_RAMSEL_n) begin
                        state_nx = ST_COUNT;
                        cnt_nx   = CW'(RAM_WAIT);
                    end else begin
                        state_nx = ST_EXTWAIT;
                        if (!i_IOSEL_n)
                            src_nx = SRC_IO;
                        else if (!i_EXPSEL_n)
                            src_nx = SRC_EXP;
                        else
                            src_nx = SRC_NONE;
                    end
                end
            end
            ST_COUNT: begin
                if (as_s)
                    state_nx = ST_IDLE;
                else if (cnt == '0)
                    state_nx = ST_ACK;
                else
                    cnt_nx = cnt - CW'(1);
            end
            ST_EXTWAIT: begin
                // Acknowledge beats a coincident timeout
                if (as_s)
                    state_nx = ST_IDLE;
                else if (ack_hit)
                    state_nx = ST_ACK;
                else if (cnt == CW'(TIMEOUT - 1))
                    state_nx = ST_BERR;
                else
                    cnt_nx = cnt + CW'(1);
            end
            ST_ACK, ST_BERR: begin
                if (as_s)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state   <= ST_IDLE;
            src     <= SRC_NONE;
            cnt     <= '0;
            as_prev <= 1'b1;
        end else begin
            state   <= state_nx;
            src     <= src_nx;
            cnt     <= cnt_nx;
            as_prev <= as_s;
        end
    end

    // Outputs come straight from flops fed by the next state: glitch-free
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            o_DTACK_n <= 1'b1;
            o_BERR_n  <= 1'b1;
            o_BUSY    <= 1'b0;
        end else begin
            o_DTACK_n <= (state_nx != ST_ACK);
            o_BERR_n  <= (state_nx != ST_BERR);
            o_BUSY    <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_bus_ack_gen.sv
// Directed self-checking bench for bus_ack_gen with default parameters.
// Edge Pk is the k-th rising edge after AS_n is driven low (P0 first).
module tb_bus_ack_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic as_n = 1'b1;
    logic romsel_n = 1'b1;
    logic ramsel_n = 1'b1;
    logic iosel_n = 1'b1;
    logic expsel_n = 1'b1;
    logic iodt_n = 1'b1;
    logic expdt_n = 1'b1;
    logic dtack_n;
    logic berr_n;
    logic busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_ack_gen dut (
        .i_CLK        (clk),
        .i_RESET_n    (rst_n),
        .i_AS_n       (as_n),
        .i_ROMSEL_n   (romsel_n),
        .i_RAMSEL_n   (ramsel_n),
        .i_IOSEL_n    (iosel_n),
        .i_EXPSEL_n   (expsel_n),
        .i_IODTACK_n  (iodt_n),
        .i_EXPDTACK_n (expdt_n),
        .o_DTACK_n    (dtack_n),
        .o_BERR_n     (berr_n),
        .o_BUSY       (busy)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_cycle(input logic rom, input logic ram,
                               input logic io, input logic exp);
        @(negedge clk);
        romsel_n = rom;
        ramsel_n = ram;
        iosel_n  = io;
        expsel_n = exp;
        as_n     = 1'b0;
    endtask

    task automatic end_cycle;
        @(negedge clk);
        as_n    = 1'b1;
        iodt_n  = 1'b1;
        expdt_n = 1'b1;
        step(3);
        romsel_n = 1'b1;
        ramsel_n = 1'b1;
        iosel_n  = 1'b1;
        expsel_n = 1'b1;
        step(2);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({dtack_n, berr_n, busy} !== 3'b110) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=110", {dtack_n, berr_n, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        checks++;
        if ({dtack_n, berr_n, busy} !== 3'b110) begin
            failures++;
            $display("FAIL reset_idle got=%b want=110", {dtack_n, berr_n, busy});
        end
    endtask

    task automatic test_rom;
        start_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        step(5);
        checks++;
        if (dtack_n !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rom_p4 dtack=%b busy=%b want 1 1", dtack_n, busy);
        end
        step(1);
        checks++;
        if (dtack_n !== 1'b0 || berr_n !== 1'b1) begin
            failures++;
            $display("FAIL rom_p5 dtack=%b berr=%b want 0 1", dtack_n, berr_n);
        end
        @(negedge clk);
        as_n = 1'b1;
        step(2);
        checks++;
        if (dtack_n !== 1'b0) begin
            failures++;
            $display("FAIL rom_hold dtack=%b want 0", dtack_n);
        end
        step(1);
        checks++;
        if (dtack_n !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rom_release dtack=%b busy=%b want 1 0", dtack_n, busy);
        end
        end_cycle();
    endtask

    task automatic test_ram;
        start_cycle(1'b1, 1'b0, 1'b1, 1'b1);
        step(3);
        checks++;
        if (dtack_n !== 1'b1) begin
            failures++;
            $display("FAIL ram_p2 dtack=%b want 1", dtack_n);
        end
        step(1);
        checks++;
        if (dtack_n !== 1'b0 || berr_n !== 1'b1) begin
            failures++;
            $display("FAIL ram_p3 dtack=%b berr=%b want 0 1", dtack_n, berr_n);
        end
        end_cycle();
    endtask

    task automatic test_io;
        start_cycle(1'b1, 1'b1, 1'b0, 1'b1);
        step(5);
        iodt_n = 1'b0;
        step(2);
        checks++;
        if (dtack_n !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL io_p6 dtack=%b busy=%b want 1 1", dtack_n, busy);
        end
        step(1);
        checks++;
        if (dtack_n !== 1'b0 || berr_n !== 1'b1) begin
            failures++;
            $display("FAIL io_p7 dtack=%b berr=%b want 0 1", dtack_n, berr_n);
        end
        end_cycle();
        checks++;
        if (dtack_n !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL io_release dtack=%b busy=%b want 1 0", dtack_n, busy);
        end
    endtask

    task automatic test_timeout;
        start_cycle(1'b1, 1'b1, 1'b1, 1'b1);
        step(66);
        checks++;
        if (berr_n !== 1'b1 || dtack_n !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL to_p65 berr=%b dtack=%b busy=%b want 1 1 1", berr_n, dtack_n, busy);
        end
        step(1);
        checks++;
        if (berr_n !== 1'b0 || dtack_n !== 1'b1) begin
            failures++;
            $display("FAIL to_p66 berr=%b dtack=%b want 0 1", berr_n, dtack_n);
        end
        @(negedge clk);
        as_n = 1'b1;
        step(2);
        checks++;
        if (berr_n !== 1'b0) begin
            failures++;
            $display("FAIL to_hold berr=%b want 0", berr_n);
        end
        step(1);
        checks++;
        if (berr_n !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL to_release berr=%b busy=%b want 1 0", berr_n, busy);
        end
        end_cycle();
    endtask

    task automatic test_tie;
        start_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        step(64);
        expdt_n = 1'b0;
        step(2);
        checks++;
        if (dtack_n !== 1'b1 || berr_n !== 1'b1) begin
            failures++;
            $display("FAIL tie_p65 dtack=%b berr=%b want 1 1", dtack_n, berr_n);
        end
        step(1);
        checks++;
        if (dtack_n !== 1'b0 || berr_n !== 1'b1) begin
            failures++;
            $display("FAIL tie_p66 dtack=%b berr=%b want 0 1", dtack_n, berr_n);
        end
        end_cycle();
    endtask

    task automatic test_abort;
        int bad;
        bad = 0;
        start_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        step(3);
        as_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (dtack_n !== 1'b1 || berr_n !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_pulse low_samples=%0d want 0", bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy busy=%b want 0", busy);
        end
        end_cycle();
    endtask

    task automatic test_reset_mid;
        start_cycle(1'b1, 1'b1, 1'b1, 1'b1);
        step(11);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy_before busy=%b want 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dtack_n, berr_n, busy} !== 3'b110) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b want=110", {dtack_n, berr_n, busy});
        end
        as_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        checks++;
        if ({dtack_n, berr_n, busy} !== 3'b110) begin
            failures++;
            $display("FAIL rstmid_after got=%b want=110", {dtack_n, berr_n, busy});
        end
        end_cycle();
    endtask

    task automatic test_sel_change;
        start_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        step(3);
        romsel_n = 1'b1;
        ramsel_n = 1'b0;
        step(2);
        checks++;
        if (dtack_n !== 1'b1) begin
            failures++;
            $display("FAIL selchg_p4 dtack=%b want 1", dtack_n);
        end
        step(1);
        checks++;
        if (dtack_n !== 1'b0) begin
            failures++;
            $display("FAIL selchg_p5 dtack=%b want 0", dtack_n);
        end
        end_cycle();
    endtask

    task automatic test_back_to_back;
        start_cycle(1'b1, 1'b0, 1'b1, 1'b1);
        step(4);
        checks++;
        if (dtack_n !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first dtack=%b want 0", dtack_n);
        end
        @(negedge clk);
        as_n = 1'b1;
        step(3);
        checks++;
        if (dtack_n !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap dtack=%b busy=%b want 1 0", dtack_n, busy);
        end
        start_cycle(1'b1, 1'b0, 1'b1, 1'b1);
        step(3);
        checks++;
        if (dtack_n !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_p2 dtack=%b busy=%b want 1 1", dtack_n, busy);
        end
        step(1);
        checks++;
        if (dtack_n !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_p3 dtack=%b want 0", dtack_n);
        end
        end_cycle();
    endtask

    initial begin
        test_reset();
        test_rom();
        test_ram();
        test_io();
        test_timeout();
        test_tie();
        test_abort();
        test_reset_mid();
        test_sel_change();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_ack_gen.md
BUS_ACK_GEN -- requirements
Module: bus_ack_gen

Interface
REQ-001 SHALL have parameter ROM_WAIT, default 2: wait cycles for ROM accesses.
REQ-002 SHALL have parameter RAM_WAIT, default 0: wait cycles for RAM accesses.
REQ-003 SHALL have parameter TIMEOUT, default 64: cycles allowed for an external DTACK before bus error.
REQ-004 SHALL have one clock and an asynchronous active-low reset: i_CLK input 1 (system clock, all state on rising edge); i_RESET_n input 1 (async active-low reset).
REQ-005 SHALL have i_AS_n input 1: CPU address strobe, asynchronous to i_CLK.
REQ-006 SHALL have i_ROMSEL_n input 1: ROM select from address decoder (even OR odd ROM enable).
REQ-007 SHALL have i_RAMSEL_n input 1: RAM select from address decoder (even OR odd RAM enable).
REQ-008 SHALL have i_IOSEL_n input 1: IO select from address decoder.
REQ-009 SHALL have i_EXPSEL_n input 1: expansion select from address decoder.
REQ-010 SHALL have i_IODTACK_n input 1: IO device acknowledge, asynchronous.
REQ-011 SHALL have i_EXPDTACK_n input 1: expansion card acknowledge, asynchronous.
REQ-012 SHALL have o_DTACK_n output 1: registered data-transfer acknowledge to the CPU.
REQ-013 SHALL have o_BERR_n output 1: registered bus error to the CPU.
REQ-014 SHALL have o_BUSY output 1: high while a bus cycle is in progress (state not IDLE).

Function
REQ-015 SHALL pass i_AS_n, i_IODTACK_n and i_EXPDTACK_n through two-flop synchronizers (as_s, iodt_s, expdt_s); selects are sampled directly, since they are stable while AS_n is low.
REQ-016 SHALL implement states IDLE, COUNT, EXTWAIT, ACK and BERR.
REQ-017 In IDLE, on the edge where as_s is first low, SHALL decode the selects with priority ROM > RAM > IO > EXP.
REQ-018 On that IDLE decode, SHALL go to COUNT with cnt = ROM_WAIT or RAM_WAIT for ROM or RAM, or to EXTWAIT with timer = 0 for IO, EXP, or no select.
REQ-019 In COUNT, SHALL go to ACK if cnt == 0, else decrement cnt; o_DTACK_n therefore falls exactly W+1 cycles after the decode edge (W=0 gives 1 cycle).
REQ-020 In EXTWAIT with IO selected, SHALL go to ACK when iodt_s is low.
REQ-021 In EXTWAIT with EXP selected, SHALL go to ACK when expdt_s is low.
REQ-022 In EXTWAIT with no select, SHALL never acknowledge.
REQ-023 In EXTWAIT, SHALL increment the timer each cycle and go to BERR when timer == TIMEOUT-1 with no ack.
REQ-024 If the ack and the timeout occur on the same edge, ACK SHALL win.
REQ-025 o_DTACK_n SHALL be low exactly while in ACK, and o_BERR_n low exactly while in BERR; the two SHALL never be low together.
REQ-026 From ACK or BERR, SHALL return to IDLE on the edge as_s is high, deasserting the output on that same edge.
REQ-027 If as_s goes high in COUNT or EXTWAIT (aborted cycle), SHALL return to IDLE with no DTACK or BERR pulse.
REQ-028 A new cycle SHALL begin only from IDLE, so back-to-back cycles need at least one IDLE cycle.
REQ-029 The cnt/timer width SHALL be $clog2(max(ROM_WAIT,RAM_WAIT,TIMEOUT)+1), with no wrap.
REQ-030 A select change during a cycle SHALL be ignored; the decision is latched at the decode edge.

Reset
REQ-031 While i_RESET_n is low, asynchronously: state = IDLE, cnt = timer = 0.
REQ-032 While i_RESET_n is low: all synchronizer flops = 1, o_DTACK_n = 1, o_BERR_n = 1, o_BUSY = 0.
REQ-033 Reset asserted mid-cycle SHALL abort immediately with no glitch low on o_DTACK_n or o_BERR_n.
REQ-034 After reset release, the first cycle SHALL be decoded only after as_s is seen high then low.

Structure
REQ-035 Shared package rosco_bus_pkg SHALL hold the state encoding and the default ROM_WAIT, RAM_WAIT and TIMEOUT constants.
REQ-036 SHALL use one sub-module, sync2 (2-flop synchronizer, async reset to 1), instantiated three times.

Verification
REQ-037 ROM: ROM_WAIT=2, ROMSEL_n=0, AS_n low -> o_DTACK_n low 3 cycles after decode edge; high after AS_n high plus sync delay.
REQ-038 RAM: RAM_WAIT=0, RAMSEL_n=0 -> o_DTACK_n low 1 cycle after decode; o_BERR_n stays 1.
REQ-039 IO: IOSEL_n=0, IODTACK_n low 5 cycles after AS_n -> o_DTACK_n low 2 sync cycles after it; no BERR.
REQ-040 Timeout: no select, AS_n low held -> o_BERR_n low at timer 63 (TIMEOUT=64); o_DTACK_n stays 1; release on AS_n high.
REQ-041 Abort/reset: AS_n high during COUNT -> no DTACK pulse; i_RESET_n low during EXTWAIT -> outputs 1 at once, o_BUSY=0.
REQ-042 Tie: EXPDTACK_n timed so expdt_s falls on the timeout edge -> o_DTACK_n low, o_BERR_n stays 1.
